// File: rtl/v_hier_iosig_pkg.sv
// Shared definitions for the iosig pad-bus sequencer.
//   - iosig_state_e : sequencer FSM states
//   - IOSIG_WIDTH   : default pad bus width
//   - iosig_max3    : helper for sizing the shared phase counter
package v_hier_iosig_pkg;

  localparam int IOSIG_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_TURN   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } iosig_state_e;

  function automatic int iosig_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/v_hier_iosig_iob.sv
// Pad-side flops of the iosig bus, kept in their own module so that the
// useioff attribute lands on these registers only.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   oe_d      : next value of the output enable
//   out_we    : load out_d into the output data register
//   out_d     : new output data
//   io_in     : raw pad input
//   io_oe     : registered pad output enable
//   io_out    : registered pad output data (holds while not loaded)
//   io_in_q   : pad input delayed by one cycle
module v_hier_iosig_iob
  import v_hier_iosig_pkg::*;
#(
  parameter int WIDTH = IOSIG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe_d,
  input  logic             out_we,
  input  logic [WIDTH-1:0] out_d,
  input  logic [WIDTH-1:0] io_in,
  output logic             io_oe,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_in_q
);

  (* useioff = 1 *) logic             io_oe_q;
  (* useioff = 1 *) logic [WIDTH-1:0] io_out_q;
  (* useioff = 1 *) logic [WIDTH-1:0] io_in_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      io_oe_q  <= 1'b0;
      io_out_q <= '0;
    end else begin
      io_oe_q <= oe_d;
      if (out_we) io_out_q <= out_d;
    end
  end

  // Input capture carries data only, so it runs free through reset.
  always_ff @(posedge clk) begin
    io_in_r <= io_in;
  end

  assign io_oe   = io_oe_q;
  assign io_out  = io_out_q;
  assign io_in_q = io_in_r;

endmodule

// File: rtl/v_hier_iosig_ctrl.sv
// Sequencer for the bidirectional iosig pad bus. Converts one read or write
// request at a time into drive / turnaround / settle pad activity and
// returns one response per request. Write responses carry the pad readback
// from the last drive cycle and flag a mismatch against the driven data.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write, req_data : 1 = write with req_data, 0 = read
//   rsp_valid/rsp_ready : response handshake, response held until consumed
//   rsp_data, rsp_err   : read value / write readback, readback mismatch
//   io_out, io_oe       : registered pad data and output enable
//   io_in               : pad input (captured in the IOB flop)
module v_hier_iosig_ctrl
  import v_hier_iosig_pkg::*;
#(
  parameter int WIDTH      = IOSIG_WIDTH,
  parameter int HOLD_CYC   = 2,
  parameter int TURN_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] io_out,
  output logic             io_oe,
  input  logic [WIDTH-1:0] io_in
);

  localparam int CNT_MAX = iosig_max3(HOLD_CYC, TURN_CYC, SETTLE_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_HOLD   = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CNT_TURN   = CW'(TURN_CYC);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_CYC);

  iosig_state_e     state_q;
  logic [CW-1:0]    cnt_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic             accept;
  logic             oe_d;
  logic             out_we;
  logic [WIDTH-1:0] io_in_q;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // The enable is raised on a write accept and dropped after the last
  // drive cycle, so the registered io_oe lines up with the DRIVE state.
  always_comb begin
    oe_d   = 1'b0;
    out_we = 1'b0;
    if (accept && req_write) begin
      oe_d   = 1'b1;
      out_we = 1'b1;
    end else if ((state_q == ST_DRIVE) && (cnt_q != CNT_ONE)) begin
      oe_d = 1'b1;
    end
  end

  v_hier_iosig_iob #(
    .WIDTH (WIDTH)
  ) u_iob (
    .clk     (clk),
    .rst     (rst),
    .oe_d    (oe_d),
    .out_we  (out_we),
    .out_d   (req_data),
    .io_in   (io_in),
    .io_oe   (io_oe),
    .io_out  (io_out),
    .io_in_q (io_in_q)
  );

  // io_out holds the latched write data for the whole transaction, so it
  // doubles as the reference for the readback comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_write) begin
              state_q <= ST_DRIVE;
              cnt_q   <= CNT_HOLD;
            end else begin
              state_q <= ST_SETTLE;
              cnt_q   <= CNT_SETTLE;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_TURN;
            cnt_q   <= CNT_TURN;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_TURN: begin
          // First turnaround cycle: io_in_q still shows the last driven cycle.
          if (cnt_q == CNT_TURN) begin
            rsp_data_q <= io_in_q;
            rsp_err_q  <= (io_in_q != io_out);
          end
          if (cnt_q == CNT_ONE) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= io_in_q;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
